// File: rtl/dsram_responder.sv
// dsram_responder: word-addressed data SRAM model answering a core's data SRAM
// port. Writes commit at the accepting edge; reads return after WAIT stall
// cycles with a one-cycle resp_valid pulse. Out-of-range accesses are flagged
// on addr_err; writes are dropped and reads return zero.
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   rst         asynchronous active-low reset
//   sram_en     request strobe
//   sram_wen    byte write enables (0 = read)
//   sram_addr   byte address
//   sram_wdata  write data
//   sram_rdata  registered read data, held between responses
//   resp_valid  one-cycle pulse marking a new read result
//   stallreq    registered stall request, high for the WAIT cycles of a read
//   addr_err    one-cycle pulse flagging an out-of-range request
module dsram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        resp_valid,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] w_idx_nxt;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  r_oor;
  logic                  w_oor_nxt;
  logic                  w_oor;
  logic                  w_accept;
  logic                  w_is_wr;
  logic                  w_mem_we;
  logic [DATA_W-1:0]     w_wr_word;
  logic [DATA_W-1:0]     w_rdata_nxt;
  logic                  w_valid_nxt;
  logic                  w_stall_nxt;
  logic                  w_err_nxt;
  logic [1:0]            w_unused_lsb;

  // Request decode: word index, range check, acceptance (never while stalling).
  assign w_idx        = sram_addr[DEPTH_LOG2+1:2];
  assign w_oor        = |(sram_addr >> (DEPTH_LOG2 + 2));
  assign w_unused_lsb = sram_addr[1:0];
  assign w_accept     = sram_en && (r_state != S_WAIT);
  assign w_is_wr      = |sram_wen;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_state_nxt = S_IDLE;
        if (w_accept && !w_is_wr) w_state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_rdata_nxt = sram_rdata;
    w_valid_nxt = 1'b0;
    w_stall_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_oor_nxt   = r_oor;
    w_mem_we    = 1'b0;
    // Read-modify-write merge so unselected byte lanes keep their contents.
    w_wr_word   = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (sram_wen[b]) w_wr_word[8*b +: 8] = sram_wdata[8*b +: 8];
    end
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (w_is_wr) begin
            w_mem_we  = !w_oor;
            w_err_nxt = w_oor;
          end else if (WAIT == 0) begin
            w_rdata_nxt = w_oor ? '0 : r_mem[w_idx];
            w_valid_nxt = 1'b1;
            w_err_nxt   = w_oor;
          end else begin
            w_cnt_nxt   = WAIT_CNT;
            w_idx_nxt   = w_idx;
            w_oor_nxt   = w_oor;
            w_stall_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Memory is sampled at the last wait edge; writes are blocked while
        // waiting, so this equals the value at acceptance.
        if (r_cnt == CNT_W'(1)) begin
          w_rdata_nxt = r_oor ? '0 : r_mem[r_idx];
          w_valid_nxt = 1'b1;
          w_err_nxt   = r_oor;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_stall_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and read context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_rdata <= '0;
      resp_valid <= 1'b0;
      stallreq   <= 1'b0;
      addr_err   <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_oor      <= 1'b0;
    end else begin
      sram_rdata <= w_rdata_nxt;
      resp_valid <= w_valid_nxt;
      stallreq   <= w_stall_nxt;
      addr_err   <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_oor      <= w_oor_nxt;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_wr_word;
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: one instance with WAIT=2, one with
// WAIT=0, both DEPTH_LOG2=10. Read expectations go into per-instance queues
// and are popped when resp_valid is observed.
module tb_dsram_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, b_valid, a_stall, b_stall, a_err, b_err;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mem_a [logic [9:0]];
  logic [31:0] mem_b [logic [9:0]];
  logic [31:0] a_last;
  int          n_total = 0;
  int          n_bad   = 0;
  int          a_resp_cnt = 0;
  int          cnt_snap;

  dsram_responder #(.DEPTH_LOG2(10), .WAIT(2)) u_dut_a (
    .clk(clk), .rst(rst), .sram_en(a_en), .sram_wen(a_wen),
    .sram_addr(a_addr), .sram_wdata(a_wdata), .sram_rdata(a_rdata),
    .resp_valid(a_valid), .stallreq(a_stall), .addr_err(a_err)
  );

  dsram_responder #(.DEPTH_LOG2(10), .WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .sram_en(b_en), .sram_wen(b_wen),
    .sram_addr(b_addr), .sram_wdata(b_wdata), .sram_rdata(b_rdata),
    .resp_valid(b_valid), .stallreq(b_stall), .addr_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic is_oor(input logic [31:0] addr);
    return (addr >> 12) != 32'd0;
  endfunction

  // Response monitors.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_valid === 1'b1) begin
      a_resp_cnt++;
      if (qa.size() == 0) chk("a_unexpected_resp", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        chk("a_resp_err", 32'(a_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_resp", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        chk("b_resp_err", 32'(b_err), 32'(e.err));
      end
    end
  end

  task automatic a_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    logic oor;
    logic [9:0] idx;
    oor = is_oor(addr);
    idx = addr[11:2];
    a_en = 1'b1; a_wen = wen; a_addr = addr; a_wdata = data;
    @(negedge clk);
    a_en = 1'b0; a_wen = 4'h0;
    chk("a_wr_err", 32'(a_err), 32'(oor));
    chk("a_wr_stall", 32'(a_stall), 32'd0);
    chk("a_rdata_hold", a_rdata, a_last);
    if (!oor) mem_a[idx] = merge(mem_a.exists(idx) ? mem_a[idx] : 32'h0, wen, data);
  endtask

  // Read on instance A; with poke set, a write to the same address is held
  // on the port for the whole stall window and must be ignored.
  task automatic a_read(input logic [31:0] addr, input bit poke);
    exp_t e;
    int stalls;
    int guard;
    logic [9:0] idx;
    idx    = addr[11:2];
    e.err  = is_oor(addr);
    e.data = e.err ? 32'h0 : mem_a[idx];
    qa.push_back(e);
    a_en = 1'b1; a_wen = 4'h0; a_addr = addr; a_wdata = 32'h0;
    @(negedge clk);
    if (poke) begin
      a_wen = 4'hF; a_wdata = 32'h5555_5555;
    end else a_en = 1'b0;
    stalls = 0;
    guard  = 0;
    while (a_valid !== 1'b1 && guard < 20) begin
      if (a_stall === 1'b1) stalls++;
      @(negedge clk);
      guard++;
    end
    a_en = 1'b0; a_wen = 4'h0;
    chk("a_resp_seen", 32'(a_valid), 32'd1);
    chk("a_stall_len", 32'(stalls), 32'd2);
    chk("a_resp_stall", 32'(a_stall), 32'd0);
    a_last = e.data;
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    logic [9:0] idx;
    idx = addr[11:2];
    b_en = 1'b1; b_wen = wen; b_addr = addr; b_wdata = data;
    @(negedge clk);
    b_en = 1'b0; b_wen = 4'h0;
    chk("b_wr_stall", 32'(b_stall), 32'd0);
    chk("b_wr_valid", 32'(b_valid), 32'd0);
    mem_b[idx] = merge(mem_b.exists(idx) ? mem_b[idx] : 32'h0, wen, data);
  endtask

  // Zero-wait read: result must appear in the very next cycle.
  task automatic b_read(input logic [31:0] addr);
    exp_t e;
    logic [9:0] idx;
    idx    = addr[11:2];
    e.err  = is_oor(addr);
    e.data = e.err ? 32'h0 : mem_b[idx];
    qb.push_back(e);
    b_en = 1'b1; b_wen = 4'h0; b_addr = addr; b_wdata = 32'h0;
    @(negedge clk);
    b_en = 1'b0;
    chk("b_resp_seen", 32'(b_valid), 32'd1);
    chk("b_stall", 32'(b_stall), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_en = 1'b0; a_wen = 4'h0; a_addr = 32'h0; a_wdata = 32'h0;
    b_en = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    a_last = 32'h0;
    @(negedge clk);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_a_err",   32'(a_err),   32'd0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    #2 rst = 1'b1;

    // Full write then read with two wait cycles.
    a_write(32'h10, 4'hF, 32'hDEAD_BEEF);
    a_read(32'h10, 1'b0);
    // Byte-lane write.
    a_write(32'h20, 4'hF, 32'h1122_3344);
    a_write(32'h20, 4'b0010, 32'h0000_AA00);
    a_read(32'h20, 1'b0);
    // Out-of-range write aliases word 0 but must not touch it.
    a_write(32'h0, 4'hF, 32'h0BAD_F00D);
    a_write(32'h1000, 4'hF, 32'hFFFF_FFFF);
    a_read(32'h0, 1'b0);
    a_read(32'h1000, 1'b0);
    // Writes presented during the stall window are ignored.
    a_read(32'h20, 1'b1);
    a_read(32'h20, 1'b0);
    // Read directly after write to the same word.
    a_write(32'h30, 4'hF, 32'hCAFE_F00D);
    a_read(32'h30, 1'b0);

    // Zero-wait instance: back-to-back reads, RAW, partial write, out of range.
    b_write(32'h0, 4'hF, 32'hA5A5_0001);
    b_write(32'h4, 4'hF, 32'h5A5A_0002);
    b_read(32'h0);
    b_read(32'h4);
    @(negedge clk);
    chk("b_valid_drop", 32'(b_valid), 32'd0);
    chk("b_rdata_hold", b_rdata, 32'h5A5A_0002);
    b_write(32'h8, 4'hF, 32'h1234_5678);
    b_read(32'h8);
    b_write(32'h8, 4'b1000, 32'hEE00_0000);
    b_read(32'h8);
    b_read(32'h1000);

    // Reset asserted in the first wait cycle aborts the read.
    a_en = 1'b1; a_wen = 4'h0; a_addr = 32'h10;
    @(negedge clk);
    a_en = 1'b0;
    chk("a_pre_rst_stall", 32'(a_stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("a_rst_rdata", a_rdata, 32'h0);
    chk("a_rst_valid", 32'(a_valid), 32'd0);
    chk("a_rst_stall", 32'(a_stall), 32'd0);
    chk("a_rst_err",   32'(a_err),   32'd0);
    cnt_snap = a_resp_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("a_no_resp_after_rst", 32'(a_resp_cnt), 32'(cnt_snap));
    a_last = 32'h0;
    a_read(32'h10, 1'b0);

    repeat (2) @(negedge clk);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
